fall_pattern_driver: RTL and testbench

Synthesizable stimulus source for the assertion training benches: it serially drives a single-bit signal `a_out` from a loaded bit pattern, one bit per clock. It also reports, cycle-accurately, where a `$fell`/`$rose` check sampling `a_out` on the same clock must pass. It is the driving end of the edge-check flow: benches connect `a_out` to the signal under assertion and compare the assertion outcome against `fell_exp`/`rose_exp`.

---
 rtl/fall_drv_pkg.sv | 11 +
 rtl/fall_pattern_driver_if.sv | 30 +++
 rtl/edge_flag.sv | 27 ++
 rtl/fall_pattern_driver.sv | 122 ++++++++++++
 tb/tb_fall_pattern_driver.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fall_drv_pkg.sv
// Shared types and defaults for the serial edge-pattern driver.
package fall_drv_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;

   typedef enum logic {
      IDLE,
      RUN
   } drv_state_t;

endpackage

// File: rtl/fall_pattern_driver_if.sv
// Load handshake and driven-signal bundle for fall_pattern_driver.
interface fall_pattern_driver_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) ();

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_pattern;
   logic [CNT_W-1:0] load_len;
   logic             load_repeat;
   logic             stop;
   logic             a_out;
   logic             fell_exp;
   logic             rose_exp;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] fall_count;

   modport master (
      output load_valid, load_pattern, load_len, load_repeat, stop,
      input  load_ready, a_out, fell_exp, rose_exp, busy, done, fall_count
   );

   modport slave (
      input  load_valid, load_pattern, load_len, load_repeat, stop,
      output load_ready, a_out, fell_exp, rose_exp, busy, done, fall_count
   );

endinterface

// File: rtl/edge_flag.sv
// Registered old/new compare: flags a 1->0 or 0->1 transition taken on this edge.
module edge_flag (
   input  logic clk,
   input  logic rst,
   input  logic i_old,
   input  logic i_new,
   output logic o_fell,
   output logic o_rose
);

   logic r_fell;
   logic r_rose;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fell <= 1'b0;
         r_rose <= 1'b0;
      end else begin
         r_fell <= i_old & ~i_new;
         r_rose <= ~i_old & i_new;
      end
   end

   assign o_fell = r_fell;
   assign o_rose = r_rose;

endmodule

// File: rtl/fall_pattern_driver.sv
// Serially drives a_out from a loaded pattern (LSB first) and reports the
// edges a same-clock $fell/$rose check on a_out will see.
module fall_pattern_driver
   import fall_drv_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   fall_pattern_driver_if.slave bus
);

   localparam int unsigned      IDX_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   drv_state_t       r_state;
   logic [WIDTH-1:0] r_pat;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_idx;
   logic [CNT_W-1:0] r_fall_cnt;
   logic             r_rep;
   logic             r_stop;
   logic             r_a;
   logic             r_done;
   logic             r_zero_pend;

   logic [CNT_W-1:0] w_len;
   logic             w_accept;
   logic             w_at_end;
   logic             w_wrap;
   logic             w_a_next;
   logic             w_fell_now;
   logic             w_fell;
   logic             w_rose;

   always_comb begin
      w_len    = (bus.load_len > LEN_MAX) ? LEN_MAX : bus.load_len;
      w_accept = bus.load_valid && (r_state == IDLE);
      w_at_end = (r_idx >= r_len);
      // A stop raised in the final cycle of a pass still ends the run there.
      w_wrap   = r_rep && !(r_stop || bus.stop);
      w_a_next = r_a;
      if (r_state == IDLE) begin
         if (w_accept && (w_len != '0)) w_a_next = bus.load_pattern[0];
      end else if (!w_at_end) begin
         w_a_next = r_pat[r_idx[IDX_W-1:0]];
      end else if (w_wrap) begin
         w_a_next = r_pat[0];
      end
      w_fell_now = r_a & ~w_a_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pat       <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_fall_cnt  <= '0;
         r_rep       <= 1'b0;
         r_stop      <= 1'b0;
         r_a         <= 1'b0;
         r_done      <= 1'b0;
         r_zero_pend <= 1'b0;
      end else begin
         r_a         <= w_a_next;
         r_done      <= r_zero_pend;
         r_zero_pend <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_pat      <= bus.load_pattern;
                  r_len      <= w_len;
                  r_rep      <= bus.load_repeat;
                  r_stop     <= 1'b0;
                  r_fall_cnt <= CNT_W'(w_fell_now);
                  if (w_len == '0) begin
                     r_zero_pend <= 1'b1;
                  end else begin
                     r_idx   <= CNT_W'(1);
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_fell_now && (r_fall_cnt != CNT_MAX)) r_fall_cnt <= r_fall_cnt + 1'b1;
               r_stop <= r_stop | bus.stop;
               if (!w_at_end) begin
                  r_idx <= r_idx + 1'b1;
               end else if (w_wrap) begin
                  r_idx <= CNT_W'(1);
               end else begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
                  r_stop  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   edge_flag u_edge_flag (
      .clk    (clk),
      .rst    (rst),
      .i_old  (r_a),
      .i_new  (w_a_next),
      .o_fell (w_fell),
      .o_rose (w_rose)
   );

   assign bus.load_ready = (r_state == IDLE);
   assign bus.busy       = (r_state == RUN);
   assign bus.a_out      = r_a;
   assign bus.fell_exp   = w_fell;
   assign bus.rose_exp   = w_rose;
   assign bus.done       = r_done;
   assign bus.fall_count = r_fall_cnt;

endmodule

// File: tb/tb_fall_pattern_driver.sv
// Directed vector table plus hand sequences for repeat/stop, back-to-back,
// clamping, saturation and mid-run reset.
module tb_fall_pattern_driver;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fall_pattern_driver_if #(.WIDTH(16)) bus ();

   fall_pattern_driver #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        valid;
      logic [15:0] pat;
      logic [4:0]  len;
      logic        rep;
      logic        a;
      logic        fell;
      logic        rose;
      logic        busy;
      logic        done;
      logic [4:0]  cnt;
   } vec_t;

   vec_t tbl[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic rep);
      bus.load_valid   = 1'b1;
      bus.load_pattern = pat;
      bus.load_len     = len;
      bus.load_repeat  = rep;
      step();
      bus.load_valid   = 1'b0;
   endtask

   initial begin
      int   n;
      int   dones;
      logic got[6];

      //           valid  pat      len    rep   | a     fell  rose  busy  done  cnt
      tbl[0]  = '{1'b1, 16'h0005, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
      tbl[1]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};
      tbl[2]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1};
      tbl[3]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2};
      tbl[4]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2};
      tbl[5]  = '{1'b1, 16'h0001, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
      tbl[6]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
      tbl[7]  = '{1'b1, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};
      tbl[8]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1};
      tbl[9]  = '{1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
      tbl[10] = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
      tbl[11] = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

      rst              = 1'b0;
      bus.load_valid   = 1'b0;
      bus.load_pattern = '0;
      bus.load_len     = '0;
      bus.load_repeat  = 1'b0;
      bus.stop         = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset a_out", bus.a_out, 0);
      check("reset fell_exp", bus.fell_exp, 0);
      check("reset rose_exp", bus.rose_exp, 0);
      check("reset done", bus.done, 0);
      check("reset busy", bus.busy, 0);
      check("reset fall_count", bus.fall_count, 0);
      check("reset load_ready", bus.load_ready, 1);
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 12; i++) begin
         bus.load_valid   = tbl[i].valid;
         bus.load_pattern = tbl[i].pat;
         bus.load_len     = tbl[i].len;
         bus.load_repeat  = tbl[i].rep;
         step();
         check($sformatf("row%0d a_out", i), bus.a_out, tbl[i].a);
         check($sformatf("row%0d fell_exp", i), bus.fell_exp, tbl[i].fell);
         check($sformatf("row%0d rose_exp", i), bus.rose_exp, tbl[i].rose);
         check($sformatf("row%0d busy", i), bus.busy, tbl[i].busy);
         check($sformatf("row%0d load_ready", i), bus.load_ready, !tbl[i].busy);
         check($sformatf("row%0d done", i), bus.done, tbl[i].done);
         check($sformatf("row%0d fall_count", i), bus.fall_count, tbl[i].cnt);
      end
      bus.load_valid = 1'b0;

      // Repeat run, stop pulsed mid third pass.
      load(16'h0001, 5'd2, 1'b1);
      got[0] = bus.a_out;
      for (int i = 1; i < 6; i++) begin
         if (i == 5) bus.stop = 1'b1;
         step();
         bus.stop = 1'b0;
         got[i] = bus.a_out;
      end
      for (int i = 0; i < 6; i++) check($sformatf("stop a_out[%0d]", i), got[i], (i % 2 == 0));
      step();
      check("stop done", bus.done, 1);
      check("stop busy", bus.busy, 0);
      check("stop fall_count", bus.fall_count, 3);
      check("stop a_out hold", bus.a_out, 0);
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.done) dones++;
      end
      check("stop extra done", dones, 0);

      // Back-to-back: 0101 then 111 loaded in the done cycle.
      load(16'h0005, 5'd4, 1'b0);
      for (int i = 0; i < 4; i++) step();
      check("b2b done", bus.done, 1);
      load(16'h0007, 5'd3, 1'b0);
      check("b2b rose_exp", bus.rose_exp, 1);
      check("b2b a_out", bus.a_out, 1);
      check("b2b busy", bus.busy, 1);
      step();
      step();
      check("b2b hold rose", bus.rose_exp, 0);
      step();
      check("b2b done2", bus.done, 1);
      check("b2b fall_count", bus.fall_count, 0);

      // Fall count saturates at 31 over a long repeating run.
      load(16'h0001, 5'd2, 1'b1);
      for (int i = 0; i < 69; i++) step();
      check("sat busy", bus.busy, 1);
      check("sat fall_count", bus.fall_count, 31);
      bus.stop = 1'b1;
      n = 0;
      while (!bus.done && n < 6) begin
         step();
         bus.stop = 1'b0;
         n++;
      end
      check("sat done seen", bus.done, 1);
      check("sat fall_count end", bus.fall_count, 31);

      // Length above WIDTH clamps to 16 bits.
      load(16'h8000, 5'd31, 1'b0);
      n = 0;
      while (!bus.done && n < 40) begin
         step();
         n++;
      end
      check("clamp done latency", n, 16);
      check("clamp a_out", bus.a_out, 1);

      // Reset mid-run at bit 2 of 8.
      load(16'h0055, 5'd8, 1'b0);
      step();
      step();
      check("pre-rst a_out", bus.a_out, 1);
      check("pre-rst fall_count", bus.fall_count, 1);
      rst = 1'b1;
      #1;
      check("rst a_out", bus.a_out, 0);
      check("rst busy", bus.busy, 0);
      check("rst fall_count", bus.fall_count, 0);
      check("rst fell/rose", {bus.fell_exp, bus.rose_exp}, 0);
      dones = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (bus.done) dones++;
      end
      rst = 1'b0;
      check("rst load_ready", bus.load_ready, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.done) dones++;
      end
      check("rst no done", dones, 0);
      check("rst a_out after", bus.a_out, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
